// File: rtl/crop_pkg.sv
// Shared types and elaboration-time helpers for the crop frame controller.
package crop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DRAIN
    } crop_state_t;

    function automatic int unsigned crop_col_limit(input int unsigned in_cols,
                                                   input int unsigned out_cols);
        return (in_cols > out_cols) ? (in_cols - out_cols) : 0;
    endfunction

    function automatic int unsigned crop_row_limit(input int unsigned in_rows,
                                                   input int unsigned out_rows);
        return (in_rows > out_rows) ? (in_rows - out_rows) : 0;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster position of the beat currently presented; holds on the last pixel.
module raster_counter #(
    parameter int COLS = 20,
    parameter int ROWS = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    output logic [$clog2(COLS)-1:0] col,
    output logic [$clog2(ROWS)-1:0] row,
    output logic                    last
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    assign last = (col == COL_MAX) && (row == ROW_MAX);

    // The final pixel does not advance, so the position parks at the frame corner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en && !last) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/crop_frame_ctrl.sv
// Frame sequencer for the crop filter: gates the pixel stream, tracks raster
// position, latches crop origin per frame and waits for downstream completion.
module crop_frame_ctrl
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20,
    parameter int OUT_ROWS        = 10,
    parameter int OUT_COLS        = 10,
    parameter int FRAME_CNT_WIDTH = 16,
    parameter int DRAIN_TIMEOUT   = 4096
) (
    input  logic                         clk,
    input  logic                         s_axis_resetn,
    input  logic                         enable,
    input  logic                         cfg_valid,
    input  logic [$clog2(IN_COLS)-1:0]   cfg_crop_x0,
    input  logic [$clog2(IN_ROWS)-1:0]   cfg_crop_y0,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0]   s_axis_tdata,
    output logic                         cf_axis_tvalid,
    input  logic                         cf_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0]   cf_axis_tdata,
    output logic [$clog2(IN_COLS)-1:0]   cnt_col,
    output logic [$clog2(IN_ROWS)-1:0]   cnt_row,
    output logic [$clog2(IN_COLS)-1:0]   crop_x0,
    output logic [$clog2(IN_ROWS)-1:0]   crop_y0,
    output logic                         ap_start,
    input  logic                         cf_ap_done,
    input  logic                         seq_ap_done,
    output logic                         busy,
    output logic [FRAME_CNT_WIDTH-1:0]   frame_count,
    output logic                         err_no_cf_done,
    output logic                         err_timeout,
    input  logic                         err_clr
);

    localparam int CW = $clog2(IN_COLS);
    localparam int RW = $clog2(IN_ROWS);
    localparam int TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CW-1:0] X_LIM  = CW'(crop_col_limit(IN_COLS, OUT_COLS));
    localparam logic [RW-1:0] Y_LIM  = RW'(crop_row_limit(IN_ROWS, OUT_ROWS));
    localparam logic [TW-1:0] T_LAST = TW'(DRAIN_TIMEOUT - 1);

    crop_state_t   state, state_nxt;
    logic [CW-1:0] pending_x0;
    logic [RW-1:0] pending_y0;
    logic          seen_cf, seen_seq;
    logic [TW-1:0] tmo_cnt;
    logic          beat_acc, last_pix;
    logic          drain_exit, timeout_hit;

    assign busy          = (state != ST_IDLE);
    assign cf_axis_tdata = s_axis_tdata;
    assign beat_acc      = (state == ST_RUN) && s_axis_tvalid && cf_axis_tready;

    always_comb begin
        state_nxt      = state;
        ap_start       = 1'b0;
        cf_axis_tvalid = 1'b0;
        s_axis_tready  = 1'b0;
        drain_exit     = 1'b0;
        timeout_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_START;
            end
            ST_START: begin
                ap_start  = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                cf_axis_tvalid = s_axis_tvalid;
                s_axis_tready  = cf_axis_tready;
                if (beat_acc && last_pix) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (seen_seq || seq_ap_done) begin
                    drain_exit = 1'b1;
                end else if (tmo_cnt == T_LAST) begin
                    drain_exit  = 1'b1;
                    timeout_hit = 1'b1;
                end
                if (drain_exit) state_nxt = enable ? ST_START : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    raster_counter #(
        .COLS (IN_COLS),
        .ROWS (IN_ROWS)
    ) u_raster (
        .clk   (clk),
        .rst_n (s_axis_resetn),
        .clr   (state == ST_START),
        .en    (beat_acc),
        .col   (cnt_col),
        .row   (cnt_row),
        .last  (last_pix)
    );

    // START loads the pending origin before a same-cycle cfg_valid overwrites it.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            state      <= ST_IDLE;
            pending_x0 <= '0;
            pending_y0 <= '0;
            crop_x0    <= '0;
            crop_y0    <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_valid) begin
                pending_x0 <= cfg_crop_x0;
                pending_y0 <= cfg_crop_y0;
            end
            if (state == ST_START) begin
                crop_x0 <= (pending_x0 > X_LIM) ? X_LIM : pending_x0;
                crop_y0 <= (pending_y0 > Y_LIM) ? Y_LIM : pending_y0;
            end
        end
    end

    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            seen_cf        <= 1'b0;
            seen_seq       <= 1'b0;
            tmo_cnt        <= '0;
            frame_count    <= '0;
            err_no_cf_done <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            if (state == ST_START) begin
                seen_cf  <= cf_ap_done;
                seen_seq <= seq_ap_done;
            end else if (state != ST_IDLE) begin
                seen_cf  <= seen_cf | cf_ap_done;
                seen_seq <= seen_seq | seq_ap_done;
            end
            if (state != ST_DRAIN) begin
                tmo_cnt <= '0;
            end else if (!drain_exit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (drain_exit) frame_count <= frame_count + 1'b1;
            // A new error in the clearing cycle takes priority over err_clr.
            err_timeout    <= timeout_hit | (err_timeout & ~err_clr);
            err_no_cf_done <= (drain_exit & ~(seen_cf | cf_ap_done)) |
                              (err_no_cf_done & ~err_clr);
        end
    end

endmodule

// File: tb/tb_crop_frame_ctrl.sv
// Bench for crop_frame_ctrl: directed and randomized frames checked each cycle
// against a frame-level reference model.
module tb_crop_frame_ctrl;

    localparam int PW     = 10;
    localparam int IN_C   = 8;
    localparam int IN_R   = 8;
    localparam int OUT_C  = 4;
    localparam int OUT_R  = 4;
    localparam int FCW    = 16;
    localparam int DTO    = 16;
    localparam int BEATS  = IN_C * IN_R;
    localparam int X_LIM  = IN_C - OUT_C;
    localparam int Y_LIM  = IN_R - OUT_R;

    localparam int P_IDLE  = 0;
    localparam int P_START = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;

    logic           clk = 1'b0;
    logic           s_axis_resetn;
    logic           enable, cfg_valid;
    logic [2:0]     cfg_crop_x0, cfg_crop_y0;
    logic           s_axis_tvalid, s_axis_tready;
    logic [PW-1:0]  s_axis_tdata;
    logic           cf_axis_tvalid, cf_axis_tready;
    logic [PW-1:0]  cf_axis_tdata;
    logic [2:0]     cnt_col, cnt_row, crop_x0, crop_y0;
    logic           ap_start, cf_ap_done, seq_ap_done, busy;
    logic [FCW-1:0] frame_count;
    logic           err_no_cf_done, err_timeout, err_clr;

    int checks = 0;
    int errors = 0;
    int ap_cnt = 0;

    // Reference model: frame phase, beat index within the frame, drain time spent.
    int m_phase, m_beat, m_drain, m_px, m_py, m_x0, m_y0, m_fc;
    bit m_cf, m_seq, m_errt, m_errc;

    crop_frame_ctrl #(
        .PIXEL_BIT_WIDTH (PW),
        .IN_ROWS         (IN_R),
        .IN_COLS         (IN_C),
        .OUT_ROWS        (OUT_R),
        .OUT_COLS        (OUT_C),
        .FRAME_CNT_WIDTH (FCW),
        .DRAIN_TIMEOUT   (DTO)
    ) dut (
        .clk            (clk),
        .s_axis_resetn  (s_axis_resetn),
        .enable         (enable),
        .cfg_valid      (cfg_valid),
        .cfg_crop_x0    (cfg_crop_x0),
        .cfg_crop_y0    (cfg_crop_y0),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .cf_axis_tvalid (cf_axis_tvalid),
        .cf_axis_tready (cf_axis_tready),
        .cf_axis_tdata  (cf_axis_tdata),
        .cnt_col        (cnt_col),
        .cnt_row        (cnt_row),
        .crop_x0        (crop_x0),
        .crop_y0        (crop_y0),
        .ap_start       (ap_start),
        .cf_ap_done     (cf_ap_done),
        .seq_ap_done    (seq_ap_done),
        .busy           (busy),
        .frame_count    (frame_count),
        .err_no_cf_done (err_no_cf_done),
        .err_timeout    (err_timeout),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("mismatch on %s", tag);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_beat = 0; m_drain = 0;
        m_px = 0; m_py = 0; m_x0 = 0; m_y0 = 0; m_fc = 0;
        m_cf = 0; m_seq = 0; m_errt = 0; m_errc = 0;
    endtask

    task automatic model_step(input bit en, input bit cfgv, input int cx, input int cy,
                              input bit tv, input bit tr, input bit cfd, input bit sqd,
                              input bit clr);
        bit set_t, set_c, done;
        set_t = 0; set_c = 0; done = 0;
        case (m_phase)
            P_IDLE: if (en) m_phase = P_START;
            P_START: begin
                m_x0 = (m_px < X_LIM) ? m_px : X_LIM;
                m_y0 = (m_py < Y_LIM) ? m_py : Y_LIM;
                m_beat = 0; m_cf = cfd; m_seq = sqd;
                m_phase = P_RUN;
            end
            P_RUN: begin
                m_cf = m_cf | cfd; m_seq = m_seq | sqd;
                if (tv && tr) begin
                    if (m_beat == BEATS - 1) begin
                        m_phase = P_DRAIN;
                        m_drain = 0;
                    end else begin
                        m_beat++;
                    end
                end
            end
            default: begin
                if (m_seq || sqd) done = 1;
                else if (m_drain == DTO - 1) begin done = 1; set_t = 1; end
                else m_drain++;
                if (done) begin
                    m_fc = (m_fc + 1) % (1 << FCW);
                    set_c = !(m_cf || cfd);
                    m_phase = en ? P_START : P_IDLE;
                end
                m_cf = m_cf | cfd; m_seq = m_seq | sqd;
            end
        endcase
        m_errt = set_t || (m_errt && !clr);
        m_errc = set_c || (m_errc && !clr);
        if (cfgv) begin m_px = cx; m_py = cy; end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance model, cross the edge.
    task automatic cycle(input bit en, input bit cfgv, input int cx, input int cy,
                         input bit tv, input bit tr, input bit cfd, input bit sqd,
                         input bit clr);
        logic [PW-1:0] d;
        d = PW'($urandom);
        enable = en; cfg_valid = cfgv; cfg_crop_x0 = 3'(cx); cfg_crop_y0 = 3'(cy);
        s_axis_tvalid = tv; cf_axis_tready = tr; s_axis_tdata = d;
        cf_ap_done = cfd; seq_ap_done = sqd; err_clr = clr;
        @(negedge clk);
        if (ap_start) ap_cnt++;
        check("busy", busy, m_phase != P_IDLE);
        check("ap_start", ap_start, m_phase == P_START);
        check("cf_tvalid", cf_axis_tvalid, (m_phase == P_RUN) && tv);
        check("s_tready", s_axis_tready, (m_phase == P_RUN) && tr);
        check("cnt_col", cnt_col, m_beat % IN_C);
        check("cnt_row", cnt_row, m_beat / IN_C);
        check("crop_xy", {crop_y0, crop_x0}, {3'(m_y0), 3'(m_x0)});
        check("frame_count", frame_count, m_fc);
        check("errs", {err_timeout, err_no_cf_done}, {m_errt, m_errc});
        if (m_phase == P_RUN) check("tdata", cf_axis_tdata, d);
        model_step(en, cfgv, cx, cy, tv, tr, cfd, sqd, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_axis_resetn = 1'b0;
        #1;
        model_reset();
        check("rst_busy", busy, 0);
        check("rst_ap_start", ap_start, 0);
        check("rst_handshake", {cf_axis_tvalid, s_axis_tready}, 0);
        check("rst_cnt", {cnt_row, cnt_col}, 0);
        check("rst_crop", {crop_y0, crop_x0}, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_errs", {err_timeout, err_no_cf_done}, 0);
        @(posedge clk);
        #1;
        s_axis_resetn = 1'b1;
    endtask

    initial begin
        s_axis_resetn = 1'b0; enable = 0; cfg_valid = 0; cfg_crop_x0 = 0; cfg_crop_y0 = 0;
        s_axis_tvalid = 1; cf_axis_tready = 1; s_axis_tdata = 0;
        cf_ap_done = 0; seq_ap_done = 0; err_clr = 0;
        do_reset();

        // Frame 1: origin (2,3), continuous flow, enable dropped mid-frame.
        cycle(0, 1, 2, 3, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ap_cnt = 0;
        for (int i = 0; i < 75; i++)
            cycle(i < 5, 0, 0, 0, 1, 1, i == 10, i == 20, 0);
        check("ap_start_pulses", ap_cnt, 1);
        check("frame1_done", frame_count, 1);
        check("frame1_crop", {crop_y0, crop_x0}, {3'd3, 3'd2});

        // Clamped origin with random stalls, then a long randomized run.
        cycle(0, 1, 7, 6, 0, 0, 0, 0, 0);
        for (int i = 0; i < 150; i++)
            cycle(1, 0, 0, 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, 0);
        check("clamp_crop", {crop_y0, crop_x0}, {3'd4, 3'd4});
        for (int i = 0; i < 1200; i++)
            cycle($urandom_range(0, 99) < 90, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 14) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 39) == 0);

        // Settle to IDLE, then a frame with no completions at all.
        for (int i = 0; i < 120; i++)
            cycle(0, 0, 0, 0, 1, 1, 0, 1, 1);
        check("settled_idle", busy, 0);
        for (int i = 0; i < 90; i++)
            cycle(i < 3, 0, 0, 0, 1, 1, 0, 0, 0);
        check("timeout_set", err_timeout, 1);
        check("no_cf_done_set", err_no_cf_done, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("err_clr", {err_timeout, err_no_cf_done}, 0);

        // Reset in the middle of a running frame.
        for (int i = 0; i < 20; i++)
            cycle(1, 0, 0, 0, 1, 1, 0, 0, 0);
        check("mid_run_busy", busy, 1);
        do_reset();
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 0, 0, 1, 1, 0, 0, 0);
        check("post_reset_fc", frame_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crop_frame_ctrl.md
# crop_frame_ctrl

Frame-level controller that sequences the crop filter for one camera stream. It gates the incoming pixel AXI-Stream into the crop filter and generates the raster counters `cnt_col`/`cnt_row` from accepted beats. It latches per-frame crop coordinates, pulses `ap_start` at each frame boundary, and waits for downstream completion (`seq_ap_done`) before starting the next frame.

## Interface
Parameters:
- `PIXEL_BIT_WIDTH`, 10: pixel width (pass-through only).
- `IN_ROWS`, 20: rows per input frame.
- `IN_COLS`, 20: columns per input frame.
- `OUT_ROWS`, 10: crop window height.
- `OUT_COLS`, 10: crop window width.
- `FRAME_CNT_WIDTH`, 16: frame counter width.
- `DRAIN_TIMEOUT`, 4096: maximum DRAIN cycles before abandoning the wait.

Ports:
- `clk` in 1: single clock.
- `s_axis_resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: level; frames run while high.
- `cfg_valid` in 1: pulse; captures `cfg_crop_x0`/`cfg_crop_y0` into pending registers.
- `cfg_crop_x0` in $clog2(IN_COLS): requested crop column origin.
- `cfg_crop_y0` in $clog2(IN_ROWS): requested crop row origin.
- `s_axis_tvalid` in 1, `s_axis_tready` out 1, `s_axis_tdata` in PIXEL_BIT_WIDTH: upstream pixel stream.
- `cf_axis_tvalid` out 1, `cf_axis_tready` in 1, `cf_axis_tdata` out PIXEL_BIT_WIDTH: stream to the crop filter.
- `cnt_col` out $clog2(IN_COLS), `cnt_row` out $clog2(IN_ROWS): raster position of the current beat.
- `crop_x0` out $clog2(IN_COLS), `crop_y0` out $clog2(IN_ROWS): active (clamped) crop origin.
- `ap_start` out 1: one-cycle frame-start pulse to the crop filter.
- `cf_ap_done` in 1: crop filter done.
- `seq_ap_done` in 1: downstream sequence done.
- `busy` out 1: state != IDLE.
- `frame_count` out FRAME_CNT_WIDTH: completed frames.
- `err_no_cf_done` out 1, `err_timeout` out 1: sticky errors.
- `err_clr` in 1: clears both sticky errors.

## Operation
- FSM states: IDLE, START, RUN, DRAIN.
- IDLE: when `enable` = 1, go to START.
- START (one cycle):
  - `ap_start` = 1.
  - `crop_x0` <= min(pending_x0, IN_COLS-OUT_COLS); `crop_y0` <= min(pending_y0, IN_ROWS-OUT_ROWS).
  - `cnt_col`/`cnt_row` <= 0; clear the seen-cf-done and seen-seq-done flags.
  - Go to RUN.
- RUN:
  - `cf_axis_tvalid` = `s_axis_tvalid`; `s_axis_tready` = `cf_axis_tready`; tdata passes straight through, combinationally.
  - On each accepted beat (`cf_axis_tvalid && cf_axis_tready`), `cnt_col` increments. At IN_COLS-1 it wraps to 0 and `cnt_row` increments.
  - When the beat at (IN_ROWS-1, IN_COLS-1) is accepted, go to DRAIN. Counters hold there.
- Outside RUN: `cf_axis_tvalid` = 0 and `s_axis_tready` = 0 (input stalls).
- `cf_ap_done` and `seq_ap_done` are sampled in every non-IDLE state into sticky per-frame flags.
- DRAIN:
  - Exit when the seen-seq-done flag is set or `seq_ap_done` = 1.
  - Also exit when the timeout counter reaches DRAIN_TIMEOUT-1; set `err_timeout`.
  - On exit: `frame_count` increments (wraps). If cf-done was never seen this frame, set `err_no_cf_done`.
  - Next state is START if `enable`, else IDLE.
- `enable` deasserted during RUN/DRAIN: the current frame completes normally.
- `cfg_valid` in the START cycle: pending updates; START loads the old pending value. The new value applies next frame.
- Reset/clamp width rule: clamping compares at the full port width; the constants are computed at elaboration.

## Timing
- Reset values: state IDLE; `ap_start` 0, `cnt_*` 0, `crop_*` 0, pending 0, `frame_count` 0, errors 0, `busy` 0, `cf_axis_tvalid` 0, `s_axis_tready` 0.
- Async assert/sync deassert is handled externally; all flops clear on `s_axis_resetn` low. Reset mid-frame abandons the frame with no status update.
- `enable` high at edge N (IDLE) → `ap_start` high in cycle N+1 → RUN from N+2.
- First beat can be accepted in the first RUN cycle. Counter outputs are registered, so `cnt_*` reflect the beat currently presented.
- Back-to-back frames: seq-done already seen when entering DRAIN → DRAIN lasts 1 cycle → START → RUN. That gives 2 dead cycles between frames.
- `err_clr` and a same-cycle error set: set wins.

## Structure
- Package `crop_pkg`: FSM state enum (`crop_state_t`) and helper functions for clamp limits (IN_COLS-OUT_COLS, IN_ROWS-OUT_ROWS).
- One natural sub-module: `raster_counter` (col/row counter with wrap, clear, enable, last-pixel flag).

## Test plan
- IN 8x8, OUT 4x4, cfg (2,3), enable, continuous valid/ready → one `ap_start` pulse; `crop_x0`=2, `crop_y0`=3; counters walk 64 beats; DRAIN entered after beat (7,7).
- Crop clamp: cfg (7,6) with 8x8/4x4 → `crop_x0`=4, `crop_y0`=4.
- Random `cf_axis_tready` and `s_axis_tvalid` stalls → counters advance only on handshakes; exactly 64 beats per frame; no beats pass outside RUN.
- `seq_ap_done` pulsed during RUN → DRAIN lasts 1 cycle; `frame_count` 0→1; next `ap_start` 2 cycles after the last beat.
- `seq_ap_done` withheld, DRAIN_TIMEOUT=16 → `err_timeout` set after 16 DRAIN cycles; `cf_ap_done` never pulsed → `err_no_cf_done` set; `err_clr` clears both.
- `s_axis_resetn` low mid-RUN → all outputs at reset values next edge; `frame_count` stays 0.
